// File: rtl/alu_issue_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_seq_if
//  Description : Bundle of the command handshake, the ALU operand/result bus
//                and the register writeback bus of alu_issue_seq.
//                slave  = the sequencer itself
//                master = the surroundings (command source + alu16)
//  Ports       : cmd_valid/cmd_ready/cmd_op/cmd_rd/cmd_ra/cmd_rb/cmd_imm
//                alu_a/alu_b/alu_fs/alu_res
//                wb_valid/wb_rd/wb_data/zero
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_issue_seq_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_ra;
  logic [AW-1:0] cmd_rb;
  logic [DW-1:0] cmd_imm;

  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [1:0]    alu_fs;
  logic [DW-1:0] alu_res;

  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          zero;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm, alu_res,
    output cmd_ready, alu_a, alu_b, alu_fs, wb_valid, wb_rd, wb_data, zero
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm, alu_res,
    input  cmd_ready, alu_a, alu_b, alu_fs, wb_valid, wb_rd, wb_data, zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_seq
//  Description : Command sequencer and register file placed in front of an
//                external combinational ALU (alu16). Accepts one command at a
//                time, drives registered ALU operands, captures the ALU
//                result and writes it back. ADDN repeats an add by feeding
//                the ALU result back into operand A.
//  Ports       : clk    rising-edge clock
//                reset  synchronous active-high reset
//                bus    alu_issue_seq_if.slave (command, ALU, writeback)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_issue_seq #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  wire logic          clk,
  input  wire logic          reset,
  alu_issue_seq_if.slave     bus
);

  localparam logic [2:0] c_op_mov  = 3'b000;
  localparam logic [2:0] c_op_inc  = 3'b001;
  localparam logic [2:0] c_op_add  = 3'b010;
  localparam logic [2:0] c_op_sub  = 3'b011;
  localparam logic [2:0] c_op_ldi  = 3'b100;
  localparam logic [2:0] c_op_addn = 3'b110;

  localparam logic [1:0] c_fs_pass = 2'b00;
  localparam logic [1:0] c_fs_inc  = 2'b01;
  localparam logic [1:0] c_fs_add  = 2'b10;
  localparam logic [1:0] c_fs_sub  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_regs [NREG];
  logic [AW-1:0] r_rd;
  logic          r_is_addn;
  logic [3:0]    r_cnt;

  logic          r_cmd_ready;
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic [1:0]    r_alu_fs;
  logic          r_wb_valid;
  logic [AW-1:0] r_wb_rd;
  logic [DW-1:0] r_wb_data;
  logic          r_zero;

  // Opcodes 101 and 111 are the two NOP encodings.
  logic          w_is_nop;
  logic [DW-1:0] w_src_a;
  logic [DW-1:0] w_src_b;

  assign w_is_nop = bus.cmd_op[2] & bus.cmd_op[0];
  assign w_src_a  = r_regs[bus.cmd_ra];
  assign w_src_b  = r_regs[bus.cmd_rb];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_rd        <= '0;
      r_is_addn   <= 1'b0;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_fs    <= c_fs_pass;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // cmd_ready is high throughout IDLE, so valid alone accepts.
          if (bus.cmd_valid && !w_is_nop) begin
            r_state     <= S_EXEC;
            r_cmd_ready <= 1'b0;
            r_rd        <= bus.cmd_rd;
            r_is_addn   <= (bus.cmd_op == c_op_addn);
            r_cnt       <= bus.cmd_imm[3:0];
            // Operands not used by an opcode keep their previous value.
            case (bus.cmd_op)
              c_op_mov: begin
                r_alu_b  <= w_src_b;
                r_alu_fs <= c_fs_pass;
              end
              c_op_inc: begin
                r_alu_b  <= w_src_b;
                r_alu_fs <= c_fs_inc;
              end
              c_op_add, c_op_addn: begin
                r_alu_a  <= w_src_a;
                r_alu_b  <= w_src_b;
                r_alu_fs <= c_fs_add;
              end
              c_op_sub: begin
                r_alu_a  <= w_src_a;
                r_alu_b  <= w_src_b;
                r_alu_fs <= c_fs_sub;
              end
              c_op_ldi: begin
                r_alu_b  <= bus.cmd_imm;
                r_alu_fs <= c_fs_pass;
              end
              default: begin
                r_alu_fs <= r_alu_fs;
              end
            endcase
          end
        end

        S_EXEC: begin
          if (r_is_addn && (r_cnt != 4'd0)) begin
            // Accumulate: alu_a becomes alu_a + alu_b each pass.
            r_alu_a <= bus.alu_res;
            r_cnt   <= r_cnt - 4'd1;
          end else begin
            // ADDN's sum already sits in alu_a; other ops take the ALU output.
            r_wb_data  <= r_is_addn ? r_alu_a : bus.alu_res;
            r_wb_rd    <= r_rd;
            r_wb_valid <= 1'b1;
            r_state    <= S_WB;
          end
        end

        S_WB: begin
          r_regs[r_wb_rd] <= r_wb_data;
          r_zero          <= (r_wb_data == '0);
          r_wb_valid      <= 1'b0;
          r_cmd_ready     <= 1'b1;
          r_state         <= S_IDLE;
        end

        default: begin
          r_wb_valid  <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_fs    = r_alu_fs;
  assign bus.wb_valid  = r_wb_valid;
  assign bus.wb_rd     = r_wb_rd;
  assign bus.wb_data   = r_wb_data;
  assign bus.zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_seq
//  Description : Scoreboard bench for alu_issue_seq with a behavioural
//                alu16 stand-in and register-file reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_issue_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_seq_if #(.DW(16), .AW(3)) bus ();

  alu_issue_seq #(.DW(16), .NREG(8), .AW(3)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // alu16 stand-in
  always_comb begin
    case (bus.alu_fs)
      2'b00:   bus.alu_res = bus.alu_b;
      2'b01:   bus.alu_res = bus.alu_b + 16'd1;
      2'b10:   bus.alu_res = bus.alu_a + bus.alu_b;
      default: bus.alu_res = bus.alu_a - bus.alu_b;
    endcase
  end

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_r [8];
  int          cyc;
  int          n_checks;
  int          n_pass;
  logic        pending_zero;
  logic        exp_zero;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compares every writeback against the scoreboard head, then the
  // zero flag in the following cycle.
  initial begin
    pending_zero = 1'b0;
    forever begin
      @(negedge clk);
      if (pending_zero) begin
        chk("zero_flag", {31'd0, bus.zero}, {31'd0, exp_zero});
        pending_zero = 1'b0;
      end
      if (bus.wb_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_wb", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("wb_rd", {29'd0, bus.wb_rd}, {29'd0, e.rd});
          chk("wb_data", {16'd0, bus.wb_data}, {16'd0, e.data});
          chk("wb_latency", cyc, e.cyc);
          chk("ready_low_in_wb", {31'd0, bus.cmd_ready}, 32'd0);
          exp_zero     = (e.data == 16'd0);
          pending_zero = 1'b1;
        end
      end
    end
  end

  // Reference: ADDN yields R[ra] + n*R[rb], everything modulo 2^16.
  task automatic model_accept(input logic [2:0] op, input logic [2:0] rd,
                              input logic [2:0] ra, input logic [2:0] rb,
                              input logic [15:0] imm, input int acc);
    exp_t e;
    int   n;
    int   v;
    n = int'(imm[3:0]);
    case (op)
      3'd0: v = int'(model_r[rb]);
      3'd1: v = int'(model_r[rb]) + 1;
      3'd2: v = int'(model_r[ra]) + int'(model_r[rb]);
      3'd3: v = int'(model_r[ra]) - int'(model_r[rb]);
      3'd4: v = int'(imm);
      3'd6: v = int'(model_r[ra]) + n * int'(model_r[rb]);
      default: return;
    endcase
    e.rd   = rd;
    e.data = v[15:0];
    e.cyc  = acc + ((op == 3'd6) ? n + 2 : 2);
    model_r[rd] = e.data;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after acceptance with
  // cmd_valid still asserted.
  task automatic send(input logic [2:0] op, input logic [2:0] rd,
                      input logic [2:0] ra, input logic [2:0] rb,
                      input logic [15:0] imm);
    int guard;
    int acc;
    guard = 0;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_ra    = ra;
    bus.cmd_rb    = rb;
    bus.cmd_imm   = imm;
    bus.cmd_valid = 1'b1;
    while (bus.cmd_ready !== 1'b1) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        chk("accept_timeout", 32'd1, 32'd0);
        return;
      end
    end
    acc = cyc;
    @(posedge clk);
    model_accept(op, rd, ra, rb, imm, acc);
    @(negedge clk);
    chk("ready_after_accept", {31'd0, bus.cmd_ready},
        {31'd0, (op[2] & op[0])});
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    bus.cmd_valid = 1'b0;
    while ((sb_q.size() != 0 || pending_zero) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    chk("drain", sb_q.size(), 32'd0);
  endtask

  initial begin
    cyc           = 0;
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_rd    = '0;
    bus.cmd_ra    = '0;
    bus.cmd_rb    = '0;
    bus.cmd_imm   = '0;
    for (int i = 0; i < 8; i++) model_r[i] = 16'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_zero", {31'd0, bus.zero}, 32'd0);
    chk("rst_wb_data", {16'd0, bus.wb_data}, 32'd0);
    chk("rst_alu", {bus.alu_a[13:0], bus.alu_b, bus.alu_fs}, 32'd0);

    // Directed sequence
    send(3'd4, 3'd1, 3'd0, 3'd0, 16'h1234);
    send(3'd4, 3'd1, 3'd0, 3'd0, 16'h0005);
    send(3'd4, 3'd2, 3'd0, 3'd0, 16'h0003);
    send(3'd2, 3'd3, 3'd1, 3'd2, 16'h0000);
    send(3'd3, 3'd4, 3'd2, 3'd1, 16'h0000);
    send(3'd4, 3'd4, 3'd0, 3'd0, 16'hFFFF);
    send(3'd1, 3'd5, 3'd0, 3'd4, 16'h0000);
    send(3'd0, 3'd6, 3'd0, 3'd1, 16'h0000);
    send(3'd6, 3'd7, 3'd1, 3'd2, 16'h0004);
    send(3'd6, 3'd0, 3'd1, 3'd2, 16'h0000);
    send(3'd5, 3'd3, 3'd0, 3'd0, 16'h0000);
    send(3'd7, 3'd3, 3'd0, 3'd0, 16'h0000);
    send(3'd2, 3'd3, 3'd3, 3'd3, 16'h0000);
    drain();

    // Back-to-back random with cmd_valid held high
    for (int k = 0; k < 40; k++) begin
      send(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
           16'($urandom));
    end
    drain();

    // Random with idle gaps
    for (int k = 0; k < 25; k++) begin
      send(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
           16'($urandom));
      bus.cmd_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // Reset in the EXEC cycle of ADDN count 8
    send(3'd4, 3'd3, 3'd0, 3'd0, 16'h0007);
    send(3'd4, 3'd1, 3'd0, 3'd0, 16'h0002);
    drain();
    send(3'd6, 3'd2, 3'd1, 3'd3, 16'h0008);
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    sb_q.delete();
    pending_zero = 1'b0;
    for (int i = 0; i < 8; i++) model_r[i] = 16'd0;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_zero", {31'd0, bus.zero}, 32'd0);
    @(negedge clk);
    chk("ready_after_reset", {31'd0, bus.cmd_ready}, 32'd1);
    repeat (12) @(negedge clk);
    send(3'd0, 3'd5, 3'd0, 3'd2, 16'h0000);
    send(3'd0, 3'd6, 3'd0, 3'd1, 16'h0000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
